// File: rtl/mtr_pwm_drv.sv
// Dual-channel H-bridge PWM driver: shared 2048-clk period counter, per-channel duty shadow.
// Define MTR_PWM_NONOVERLAP_EN to add a 32-clk dead-time FSM on each channel's outputs.
module mtr_pwm_chan (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] i_spd,
    input  logic [10:0] i_cnt,
    input  logic        i_load,
    output logic        o_pwm1,
    output logic        o_pwm2
);
    logic [10:0] r_duty;
    logic        r_sig;
    logic        r_pwm1;
    logic        r_pwm2;

    // spd + 1024 modulo 2048 is just an MSB flip of the two's-complement command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= 11'd1024;
            r_sig  <= 1'b0;
        end else begin
            if (i_load)
                r_duty <= {~i_spd[10], i_spd[9:0]};
            r_sig <= (i_cnt < r_duty);
        end
    end

`ifdef MTR_PWM_NONOVERLAP_EN
    localparam logic [1:0] DEAD = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    logic [1:0] r_state;
    logic [4:0] r_dead;
    logic       r_sig_d;

    // Any edge on r_sig (re)starts a 32-clk interval with both drives off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DEAD;
            r_dead  <= 5'd0;
            r_sig_d <= 1'b0;
            r_pwm1  <= 1'b0;
            r_pwm2  <= 1'b0;
        end else begin
            r_sig_d <= r_sig;
            if (r_sig != r_sig_d) begin
                r_state <= DEAD;
                r_dead  <= 5'd0;
                r_pwm1  <= 1'b0;
                r_pwm2  <= 1'b0;
            end else if (r_state == DEAD) begin
                if (r_dead == 5'd31) begin
                    r_state <= r_sig ? HIGH : LOW;
                    r_pwm1  <= r_sig;
                    r_pwm2  <= ~r_sig;
                end else begin
                    r_dead <= r_dead + 5'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm1 <= 1'b0;
            r_pwm2 <= 1'b0;
        end else begin
            r_pwm1 <= r_sig;
            r_pwm2 <= ~r_sig;
        end
    end
`endif

    assign o_pwm1 = r_pwm1;
    assign o_pwm2 = r_pwm2;
endmodule

module mtr_pwm_drv (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] lft_spd,
    input  logic signed [10:0] rght_spd,
    output logic               lftPWM1,
    output logic               lftPWM2,
    output logic               rghtPWM1,
    output logic               rghtPWM2,
    output logic               PWM_synch
);
    localparam int NUM_CH = 2;

    logic [10:0]             r_cnt;
    logic                    r_synch;
    logic                    w_load;
    logic [NUM_CH-1:0][10:0] w_spd;
    logic [NUM_CH-1:0]       w_pwm1;
    logic [NUM_CH-1:0]       w_pwm2;

    assign w_load = (r_cnt == 11'd2047);
    assign w_spd  = {rght_spd, lft_spd};

    // Synch is registered from 2046 so it is high exactly while cnt==2047.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 11'd0;
            r_synch <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 11'd1;
            r_synch <= (r_cnt == 11'd2046);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mtr_pwm_chan u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_spd  (w_spd[g]),
            .i_cnt  (r_cnt),
            .i_load (w_load),
            .o_pwm1 (w_pwm1[g]),
            .o_pwm2 (w_pwm2[g])
        );
    end

    assign lftPWM1   = w_pwm1[0];
    assign lftPWM2   = w_pwm2[0];
    assign rghtPWM1  = w_pwm1[1];
    assign rghtPWM2  = w_pwm2[1];
    assign PWM_synch = r_synch;
endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed bench for mtr_pwm_drv: per-period high-time counts for a table of speed pairs,
// plus reset, first-period, mid-period-update and asynchronous-reset sequences.
module tb_mtr_pwm_drv;
    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, PWM_synch;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int l;
        int r;
        int lp1;
        int lp2;
        int rp1;
        int rp2;
    } vec_t;

    vec_t vt[4];

    mtr_pwm_drv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lftPWM1   (lftPWM1),
        .lftPWM2   (lftPWM2),
        .rghtPWM1  (rghtPWM1),
        .rghtPWM2  (rghtPWM2),
        .PWM_synch (PWM_synch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_synch();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4200 && !ok; i++) begin
            @(negedge clk);
            if (PWM_synch) ok = 1'b1;
        end
        if (!ok) chk("synch_timeout", 0, 1);
    endtask

    // One 2048-clk window starting at the cnt==0 cycle; optional lft_spd change mid-window.
    task automatic measure(input int chg_at, input int chg_val,
                           output int lp1, output int lp2, output int rp1, output int rp2,
                           output int sy, output int ovl, output int ovr);
        lp1 = 0; lp2 = 0; rp1 = 0; rp2 = 0; sy = 0; ovl = 0; ovr = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (i == chg_at) lft_spd = 11'(chg_val);
            lp1 += int'(lftPWM1);
            lp2 += int'(lftPWM2);
            rp1 += int'(rghtPWM1);
            rp2 += int'(rghtPWM2);
            sy  += int'(PWM_synch);
            if (lftPWM1 && lftPWM2) ovl++;
            if (rghtPWM1 && rghtPWM2) ovr++;
        end
    endtask

    initial begin
        int lp1, lp2, rp1, rp2, sy, ovl, ovr, first_sy, k1_p1, k1_p2;
        int exp_hi, exp_mid0, exp_mid1;

`ifdef MTR_PWM_NONOVERLAP_EN
        vt[0] = '{0, 0, 992, 992, 992, 992};
        vt[1] = '{-1024, 1023, 0, 2048, 2015, 0};
        vt[2] = '{-1000, 511, 0, 1992, 1503, 481};
        vt[3] = '{512, -512, 1504, 480, 480, 1504};
        exp_hi = 992; exp_mid0 = 992; exp_mid1 = 1504;
        k1_p2 = 0;
`else
        vt[0] = '{0, 0, 1024, 1024, 1024, 1024};
        vt[1] = '{-1024, 1023, 0, 2048, 2047, 1};
        vt[2] = '{-1000, 511, 24, 2024, 1535, 513};
        vt[3] = '{512, -512, 1536, 512, 512, 1536};
        exp_hi = 1024; exp_mid0 = 1024; exp_mid1 = 1536;
        k1_p2 = 1;
`endif

        rst_n = 1'b0;
        lft_spd = -11'sd1024;
        rght_spd = 11'sd1023;
        repeat (3) @(negedge clk);
        chk("rst_lftPWM1", int'(lftPWM1), 0);
        chk("rst_lftPWM2", int'(lftPWM2), 0);
        chk("rst_rghtPWM1", int'(rghtPWM1), 0);
        chk("rst_rghtPWM2", int'(rghtPWM2), 0);
        chk("rst_synch", int'(PWM_synch), 0);

        // First period after release runs at the reset duty of 1024 regardless of the inputs.
        rst_n = 1'b1;
        lp1 = 0; rp1 = 0; first_sy = -1; k1_p1 = -1;
        for (int k = 1; k <= 2048; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("k1_lftPWM1", int'(lftPWM1), 0);
                chk("k1_lftPWM2", int'(lftPWM2), k1_p2);
            end
            lp1 += int'(lftPWM1);
            rp1 += int'(rghtPWM1);
            if (PWM_synch && first_sy < 0) first_sy = k;
        end
        chk("first_synch_cycle", first_sy, 2047);
        chk("first_period_lft_hi", lp1, exp_hi);
        chk("first_period_rght_hi", rp1, exp_hi);

        for (int v = 0; v < 4; v++) begin
            lft_spd = 11'(vt[v].l);
            rght_spd = 11'(vt[v].r);
            wait_synch();
            wait_synch();
            measure(-1, 0, lp1, lp2, rp1, rp2, sy, ovl, ovr);
            chk($sformatf("v%0d_lftPWM1", v), lp1, vt[v].lp1);
            chk($sformatf("v%0d_lftPWM2", v), lp2, vt[v].lp2);
            chk($sformatf("v%0d_rghtPWM1", v), rp1, vt[v].rp1);
            chk($sformatf("v%0d_rghtPWM2", v), rp2, vt[v].rp2);
            chk($sformatf("v%0d_synch", v), sy, 1);
            chk($sformatf("v%0d_lft_overlap", v), ovl, 0);
            chk($sformatf("v%0d_rght_overlap", v), ovr, 0);
        end

        // Mid-period command change must wait for the next period boundary.
        lft_spd = 11'sd0;
        wait_synch();
        wait_synch();
        measure(500, 512, lp1, lp2, rp1, rp2, sy, ovl, ovr);
        chk("mid_cur_period_hi", lp1, exp_mid0);
        measure(-1, 0, lp1, lp2, rp1, rp2, sy, ovl, ovr);
        chk("mid_next_period_hi", lp1, exp_mid1);

        // Reset asserted between clock edges while lftPWM1 is high.
        wait_synch();
        repeat (1200) @(negedge clk);
        chk("pre_rst_lftPWM1", int'(lftPWM1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_lftPWM1", int'(lftPWM1), 0);
        chk("async_lftPWM2", int'(lftPWM2), 0);
        chk("async_rghtPWM1", int'(rghtPWM1), 0);
        chk("async_rghtPWM2", int'(rghtPWM2), 0);
        chk("async_synch", int'(PWM_synch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
